// File: rtl/io_bus_arb_pkg.sv
// Shared constants and types for the MMIO bus arbiter and its address decoder.
package io_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam logic IO_OP_READ  = 1'b0;
  localparam logic IO_OP_WRITE = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        op;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } io_req_t;

endpackage

// File: rtl/io_bus_arb_if.sv
// Two-master request/ack channels plus the shared strobe-qualified peripheral bus.
interface io_bus_arb_if #(
  parameter int NUM_SLV = 4
);
  logic                   m0_req;
  logic [31:0]            m0_addr;
  logic                   m0_op;
  logic [3:0]             m0_mask;
  logic [31:0]            m0_wdata;
  logic                   m0_ack;
  logic                   m0_err;
  logic [31:0]            m0_rdata;

  logic                   m1_req;
  logic [31:0]            m1_addr;
  logic                   m1_op;
  logic [3:0]             m1_mask;
  logic [31:0]            m1_wdata;
  logic                   m1_ack;
  logic                   m1_err;
  logic [31:0]            m1_rdata;

  logic [31:0]            io_addr;
  logic                   io_op;
  logic [3:0]             io_mask;
  logic [31:0]            io_wdata;
  logic [NUM_SLV-1:0]     io_sel;
  logic [NUM_SLV*32-1:0]  slv_rdata;

  // The arbiter's view: it serves the masters and drives the peripherals.
  modport slave (
    input  m0_req, m0_addr, m0_op, m0_mask, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_addr, m1_op, m1_mask, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output io_addr, io_op, io_mask, io_wdata, io_sel,
    input  slv_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_op, m0_mask, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_addr, m1_op, m1_mask, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  io_addr, io_op, io_mask, io_wdata, io_sel,
    output slv_rdata
  );
endinterface

// File: rtl/io_addr_dec.sv
// Peripheral index field -> one-hot select plus out-of-range error; purely combinational.
module io_addr_dec #(
  parameter int NUM_SLV = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               err
);

  assign err = (int'(idx) >= NUM_SLV);

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
      assign sel[gi] = (int'(idx) == gi);
    end
  endgenerate

endmodule

// File: rtl/io_bus_arb.sv
// Round-robin arbiter for two masters onto the single-cycle MMIO bus: IDLE -> GRANT -> RESP.
module io_bus_arb
  import io_bus_arb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SEL_LO  = 12,
  parameter int SEL_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  io_bus_arb_if.slave bus
);

  arb_state_e         state_reg;
  logic               last_gnt_reg;
  logic               owner_reg;
  io_req_t            lat_reg;
  logic [NUM_SLV-1:0] sel_reg;
  logic               op_reg;
  logic               err_reg;
  logic [31:0]        rdata_reg;
  logic [1:0]         ack_reg;

  io_req_t            m0_req_s;
  io_req_t            m1_req_s;
  io_req_t            pick_req;
  logic               pick;
  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_err;
  logic [31:0]        slv_word [NUM_SLV];
  logic [31:0]        rd_mux;
  logic [31:0]        rd_next;

  assign m0_req_s = '{addr: bus.m0_addr, op: bus.m0_op, mask: bus.m0_mask, wdata: bus.m0_wdata};
  assign m1_req_s = '{addr: bus.m1_addr, op: bus.m1_op, mask: bus.m1_mask, wdata: bus.m1_wdata};

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    pick     = (bus.m0_req && bus.m1_req) ? ~last_gnt_reg : bus.m1_req;
    pick_req = pick ? m1_req_s : m0_req_s;
  end

  io_addr_dec #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .idx (pick_req.addr[SEL_LO+SEL_W-1:SEL_LO]),
    .sel (dec_sel),
    .err (dec_err)
  );

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign slv_word[gi] = bus.slv_rdata[32*gi +: 32];
    end
  endgenerate

  // sel_reg is all-zero on a decode error, so the mux naturally returns 0 then.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_reg[k]) rd_mux = rd_mux | slv_word[k];
    end
    rd_next = (lat_reg.op == IO_OP_WRITE) ? '0 : rd_mux;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      last_gnt_reg <= 1'b1;
      owner_reg    <= 1'b0;
      lat_reg      <= '0;
      sel_reg      <= '0;
      op_reg       <= IO_OP_READ;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      ack_reg      <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          ack_reg <= '0;
          if (bus.m0_req || bus.m1_req) begin
            lat_reg      <= pick_req;
            owner_reg    <= pick;
            last_gnt_reg <= pick;
            sel_reg      <= dec_sel;
            op_reg       <= pick_req.op & ~dec_err;
            err_reg      <= dec_err;
            state_reg    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          rdata_reg <= rd_next;
          sel_reg   <= '0;
          op_reg    <= IO_OP_READ;
          ack_reg   <= owner_reg ? 2'b10 : 2'b01;
          state_reg <= ARB_RESP;
        end
        ARB_RESP: begin
          ack_reg   <= '0;
          state_reg <= ARB_IDLE;
        end
        default: begin
          ack_reg   <= '0;
          sel_reg   <= '0;
          op_reg    <= IO_OP_READ;
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.io_addr  = lat_reg.addr;
  assign bus.io_mask  = lat_reg.mask;
  assign bus.io_wdata = lat_reg.wdata;
  assign bus.io_op    = op_reg;
  assign bus.io_sel   = sel_reg;

  assign bus.m0_ack   = ack_reg[0];
  assign bus.m0_err   = ack_reg[0] & err_reg;
  assign bus.m0_rdata = ack_reg[0] ? rdata_reg : '0;
  assign bus.m1_ack   = ack_reg[1];
  assign bus.m1_err   = ack_reg[1] & err_reg;
  assign bus.m1_rdata = ack_reg[1] ? rdata_reg : '0;

endmodule

// File: tb/tb_io_bus_arb.sv
// Directed bench for io_bus_arb: a 4-slave instance with a GPIO model and a 3-slave instance for decode errors.
module tb_io_bus_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] gpio_q;

  always #5 clk = ~clk;

  io_bus_arb_if #(.NUM_SLV(4)) b  ();
  io_bus_arb_if #(.NUM_SLV(3)) b3 ();

  io_bus_arb #(.NUM_SLV(4), .SEL_LO(12), .SEL_W(2)) dut  (.clk(clk), .rst(rst), .bus(b));
  io_bus_arb #(.NUM_SLV(3), .SEL_LO(12), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // GPIO at slave 0: two output bits, written through byte lane 0.
  always_ff @(posedge clk) begin
    if (rst) gpio_q <= 2'b00;
    else if (b.io_sel[0] && b.io_op && b.io_mask[0]) gpio_q <= b.io_wdata[1:0];
  end

  assign b.slv_rdata  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, {30'd0, gpio_q}};
  assign b3.slv_rdata = {32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_00AA};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic req, input logic [31:0] addr, input logic op,
                        input logic [3:0] mask, input logic [31:0] wdata);
    b.m0_req = req; b.m0_addr = addr; b.m0_op = op; b.m0_mask = mask; b.m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic [31:0] addr, input logic op,
                        input logic [3:0] mask, input logic [31:0] wdata);
    b.m1_req = req; b.m1_addr = addr; b.m1_op = op; b.m1_mask = mask; b.m1_wdata = wdata;
  endtask

  initial begin
    set_m0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_m1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    b3.m0_req = 1'b0; b3.m0_addr = '0; b3.m0_op = 1'b0; b3.m0_mask = '0; b3.m0_wdata = '0;
    b3.m1_req = 1'b0; b3.m1_addr = '0; b3.m1_op = 1'b0; b3.m1_mask = '0; b3.m1_wdata = '0;

    tick(); tick();
    check("rst_m0_ack", 32'(b.m0_ack), 32'd0);
    check("rst_m1_ack", 32'(b.m1_ack), 32'd0);
    check("rst_io_sel", 32'(b.io_sel), 32'd0);
    check("rst_io_op", 32'(b.io_op), 32'd0);
    check("rst_io_addr", b.io_addr, 32'd0);
    rst = 1'b0;

    // m0 write of 3 to the GPIO.
    set_m0(1'b1, 32'h0000_0000, 1'b1, 4'hF, 32'h0000_0003);
    tick();
    check("wr_grant_sel", 32'(b.io_sel), 32'h1);
    check("wr_grant_op", 32'(b.io_op), 32'd1);
    check("wr_grant_wdata", b.io_wdata, 32'h3);
    check("wr_grant_ack", 32'(b.m0_ack), 32'd0);
    tick();
    check("wr_resp_ack", 32'(b.m0_ack), 32'd1);
    check("wr_resp_err", 32'(b.m0_err), 32'd0);
    check("wr_resp_rdata", b.m0_rdata, 32'd0);
    check("wr_resp_op", 32'(b.io_op), 32'd0);
    check("wr_resp_sel", 32'(b.io_sel), 32'd0);
    b.m0_req = 1'b0;
    tick();
    check("wr_idle_ack", 32'(b.m0_ack), 32'd0);
    check("wr_gpio", 32'(gpio_q), 32'h3);
    $display("txn m0 write addr=00000000 data=00000003");

    // m1 read from slave 2.
    set_m1(1'b1, 32'h0000_2004, 1'b0, 4'hF, 32'h0);
    tick();
    check("rd_grant_sel", 32'(b.io_sel), 32'h4);
    check("rd_grant_op", 32'(b.io_op), 32'd0);
    check("rd_grant_addr", b.io_addr, 32'h0000_2004);
    tick();
    check("rd_resp_ack", 32'(b.m1_ack), 32'd1);
    check("rd_resp_rdata", b.m1_rdata, 32'hDEAD_BEEF);
    check("rd_resp_err", 32'(b.m1_err), 32'd0);
    check("rd_resp_m0_ack", 32'(b.m0_ack), 32'd0);
    check("rd_resp_m0_rdata", b.m0_rdata, 32'd0);
    b.m1_req = 1'b0;
    tick();
    check("rd_idle_ack", 32'(b.m1_ack), 32'd0);
    check("rd_idle_rdata", b.m1_rdata, 32'd0);
    $display("txn m1 read addr=00002004 data=%08h", 32'hDEAD_BEEF);

    // Both masters hold req from reset: m0 write to slave 1, m1 read from slave 3.
    rst = 1'b1;
    set_m0(1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'h5);
    set_m1(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("rr%0d_m0_ack", c), 32'(b.m0_ack), 32'((c % 6) == 1));
      check($sformatf("rr%0d_m1_ack", c), 32'(b.m1_ack), 32'((c % 6) == 4));
      check($sformatf("rr%0d_io_op", c), 32'(b.io_op), 32'((c % 6) == 0));
      if ((c % 6) == 4) check($sformatf("rr%0d_m1_rdata", c), b.m1_rdata, 32'h3333_3333);
      if ((c % 3) == 1) $display("txn rr ack cycle=%0d m0_ack=%0b m1_ack=%0b", c, b.m0_ack, b.m1_ack);
      if (c == 11) begin
        b.m0_req = 1'b0;
        b.m1_req = 1'b0;
      end
    end

    // Decode error on the 3-slave build.
    b3.m0_req = 1'b1; b3.m0_addr = 32'h0000_3000; b3.m0_op = 1'b0; b3.m0_mask = 4'hF;
    tick();
    check("err_grant_sel", 32'(b3.io_sel), 32'd0);
    check("err_grant_op", 32'(b3.io_op), 32'd0);
    tick();
    check("err_resp_ack", 32'(b3.m0_ack), 32'd1);
    check("err_resp_err", 32'(b3.m0_err), 32'd1);
    check("err_resp_rdata", b3.m0_rdata, 32'd0);
    b3.m0_req = 1'b0;
    tick();
    check("err_idle_err", 32'(b3.m0_err), 32'd0);
    $display("txn nslv3 m0 read addr=00003000 err=1");

    // Reset while in GRANT aborts the transaction.
    set_m0(1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
    tick();
    check("abort_grant_sel", 32'(b.io_sel), 32'h1);
    rst = 1'b1;
    tick();
    check("abort_m0_ack", 32'(b.m0_ack), 32'd0);
    check("abort_m1_ack", 32'(b.m1_ack), 32'd0);
    check("abort_io_sel", 32'(b.io_sel), 32'd0);
    rst = 1'b0;
    b.m0_req = 1'b0;
    tick();
    check("abort_after_ack", 32'(b.m0_ack), 32'd0);
    $display("txn m0 read aborted by reset");
    set_m1(1'b1, 32'h0000_2004, 1'b0, 4'hF, 32'h0);
    tick();
    check("post_rst_sel", 32'(b.io_sel), 32'h4);
    tick();
    check("post_rst_ack", 32'(b.m1_ack), 32'd1);
    check("post_rst_rdata", b.m1_rdata, 32'hDEAD_BEEF);
    b.m1_req = 1'b0;
    tick();
    $display("txn m1 read after reset data=%08h", 32'hDEAD_BEEF);
    set_m0(1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
    set_m1(1'b1, 32'h0000_2000, 1'b0, 4'hF, 32'h0);
    tick();
    check("tie_grant_sel", 32'(b.io_sel), 32'h2);
    tick();
    check("tie_m0_ack", 32'(b.m0_ack), 32'd1);
    check("tie_m1_ack", 32'(b.m1_ack), 32'd0);
    check("tie_m0_rdata", b.m0_rdata, 32'h1111_1111);
    b.m0_req = 1'b0;
    b.m1_req = 1'b0;
    tick();
    $display("txn tie granted to m0 data=%08h", 32'h1111_1111);

    // m0 drops req during GRANT; the ack still arrives once.
    set_m0(1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
    tick();
    b.m0_req = 1'b0;
    tick();
    check("drop_ack", 32'(b.m0_ack), 32'd1);
    check("drop_rdata", b.m0_rdata, 32'h1111_1111);
    tick();
    check("drop_idle_ack", 32'(b.m0_ack), 32'd0);
    tick();
    check("drop_no_second_sel", 32'(b.io_sel), 32'd0);
    tick();
    check("drop_no_second_ack", 32'(b.m0_ack), 32'd0);
    $display("txn m0 read with req dropped in grant");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
